seq_mul16_unit: RTL and testbench
=================================

// Module: seq_mul16_unit
// PURPOSE
//  Iterative shift-and-add multiplier that feeds a 16-bit result into one channel of the ALU
//  result MUX16, beside the AND/OR/XOR/NOT/adder channels.
//  Accepts one operand pair per valid/ready handshake and computes one partial product per cycle.
//  Presents a 2*WIDTH product with an overflow flag and holds it until the consumer takes it.
// PARAMETERS
//  WIDTH   16   operand width; product is 2*WIDTH; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high; clears all state
//  in_valid   in   1        operand pair a/b/op_signed is valid
//  in_ready   out  1        unit can accept operands (IDLE only)
//  a          in   WIDTH    multiplicand
//  b          in   WIDTH    multiplier
//  op_signed  in   1        1 = two's-complement operands, 0 = unsigned
//  out_valid  out  1        product/overflow valid (DONE only)
//  out_ready  in   1        consumer accepts product
//  prod_lo    out  WIDTH    product bits [WIDTH-1:0] (drives MUX16 channel)
//  prod_hi    out  WIDTH    product bits [2W-1:WIDTH]
//  overflow   out  1        product does not fit in WIDTH bits
//  busy       out  1        state is RUN or FIX
// BEHAVIOUR
//  Reset
//  - clk and reset: reset is asynchronous, active-high; clock is clk.
//  - While reset is high: state=IDLE; prod_lo, prod_hi, overflow, out_valid, busy and the counter
//    are all 0; in_ready=1 once reset is low.
//  - Reset mid-operation aborts the op immediately; the in-flight result is discarded.
//  FSM: IDLE -> RUN -> FIX -> DONE -> IDLE
//  - IDLE: in_ready=1.
//    - On in_valid&in_ready at edge E0, capture |a|, |b| (magnitude only if op_signed),
//      plus neg = op_signed&(a[W-1]^b[W-1]).
//    - Clear acc_hi and cnt, then go to RUN.
//  - RUN: one iteration per edge (E1..E_WIDTH).
//    - If mq[0], {c,acc_hi} = acc_hi + mcand, a (WIDTH+1)-bit add; else {c,acc_hi} = {0,acc_hi}.
//    - Shift {c,acc_hi,mq} right by 1.
//    - After WIDTH iterations go to FIX.
//  - FIX: one edge.
//    - If neg, the 2W product is two's-complement negated, otherwise passed through.
//    - prod_hi/prod_lo/overflow are registered; then go to DONE.
//  - DONE: out_valid=1; outputs held stable.
//    - On out_valid&out_ready go to IDLE.
//  Timing
//  - Fixed latency: out_valid first high after edge E_(WIDTH+1), i.e. WIDTH+1 cycles after accept.
//  - Throughput: one op per >= WIDTH+3 cycles. No overlap: in_ready=0 outside IDLE.
//  - in_valid outside IDLE is ignored. a/b/op_signed are sampled only at the handshake edge.
//  - out_ready outside DONE is ignored.
//  Overflow flag
//  - unsigned: overflow = |prod_hi
//  - signed:   overflow = (prod_hi != {WIDTH{prod_lo[W-1]}})
//  Width and edge cases
//  - Magnitude of 0x8000 (signed) is 0x8000 held in WIDTH bits unsigned; no extra bit is needed.
//  - Zero operand produces a 0 product; neg with zero product still yields 0, with no -0 artefact.
//  - prod_lo/prod_hi keep their last value after the DONE handshake until the next FIX.
// TESTING
//  1. Unsigned 0xFFFF*0xFFFF, out_ready=1
//     -> hi=0xFFFE lo=0x0001 ovf=1; out_valid exactly 17 cycles after accept edge, for 1 cycle.
//  2. Signed 0xFFFD*0x0005 (-3*5) -> hi=0xFFFF lo=0xFFF1 ovf=0.
//     Signed 0x8000*0x8000 -> hi=0x4000 lo=0x0000 ovf=1.
//  3. Unsigned 0x1234*0x0001 -> 0x0000_1234 ovf=0.
//     Signed 0x0000*0x8000 -> 0 ovf=0.
//     Signed 0x7FFF*0xFFFF -> hi=0xFFFF lo=0x8001 ovf=0.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands
//     -> outputs stable, in_ready=0, new pair not taken.
//     Release out_ready -> IDLE next cycle, new pair accepted, correct result.
//  5. Assert reset at RUN iteration 8
//     -> out_valid/busy/prod_* = 0 asynchronously, before the next clk edge.
//     After release: in_ready=1, next op 0x00FF*0x0101 = 0x0000_FFFF.
//  6. Back-to-back: 20 random signed/unsigned ops with random in_valid/out_ready gaps
//     -> every result matches the reference a*b; none lost or duplicated.

Source files
------------

// File: rtl/seq_mul16_unit.sv
// Iterative shift-and-add multiplier: one partial product per clock, signed or unsigned
// operands, 2*WIDTH product with an overflow flag held until the consumer takes it.
module seq_mul16_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_mq;
    logic             r_neg;
    logic             r_signed;
    logic [WIDTH-1:0] r_prod_lo;
    logic [WIDTH-1:0] r_prod_hi;
    logic             r_ovf;

    logic             w_accept;
    logic             w_release;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg_in;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;
    logic             w_ovf;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE and out_valid only in DONE; the other side's valid/ready
    // is ignored outside those states, and operands are sampled only at the accept edge.
    assign w_accept    = in_valid & in_ready;
    assign w_release   = out_valid & out_ready;
    assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept)    w_state_nxt = S_RUN;
            S_RUN:  if (w_last_iter) w_state_nxt = S_FIX;
            S_FIX:                   w_state_nxt = S_DONE;
            S_DONE: if (w_release)   w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
    assign o_dbg_state = r_state;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Magnitudes fit in WIDTH unsigned bits: |0x8000| stays 0x8000.
    assign w_abs_a  = (op_signed & a[WIDTH-1]) ? (-a) : a;
    assign w_abs_b  = (op_signed & b[WIDTH-1]) ? (-b) : b;
    assign w_neg_in = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    assign w_addend = r_mq[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_addend};

    // Negating a zero magnitude gives zero, so no -0 can appear.
    assign w_prod = {r_acc_hi, r_mq};
    assign w_res  = r_neg ? (-w_prod) : w_prod;

    always_comb begin
        w_ovf = 1'b0;
        if (r_signed) begin
            w_ovf = (w_res[2*WIDTH-1:WIDTH] != {WIDTH{w_res[WIDTH-1]}});
        end else begin
            w_ovf = |w_res[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_mq     <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_abs_a;
                        r_mq     <= w_abs_b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_neg_in;
                        r_signed <= op_signed;
                    end
                end
                S_RUN: begin
                    // Shift {carry, acc_hi, mq} right by one after the conditional add.
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_mq     <= {w_sum[0], r_mq[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers change only in FIX, so they hold through DONE and beyond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod_lo <= '0;
            r_prod_hi <= '0;
            r_ovf     <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_prod_lo <= w_res[WIDTH-1:0];
            r_prod_hi <= w_res[2*WIDTH-1:WIDTH];
            r_ovf     <= w_ovf;
        end
    end

    assign prod_lo  = r_prod_lo;
    assign prod_hi  = r_prod_hi;
    assign overflow = r_ovf;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_valid_not_busy : assert property (@(posedge clk) disable iff (reset)
        out_valid |-> !busy);

    a_ready_excl_valid : assert property (@(posedge clk) disable iff (reset)
        in_ready |-> !out_valid);

    a_cnt_in_range : assert property (@(posedge clk) disable iff (reset)
        (r_state == S_RUN) |-> (r_cnt < CW'(WIDTH)));

    a_hold_when_stalled : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(prod_lo)
                                       && $stable(prod_hi) && $stable(overflow)));

endmodule

// File: tb/tb_seq_mul16_unit.sv
// Directed-vector and randomized scoreboard bench for seq_mul16_unit.
module tb_seq_mul16_unit;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] prod_lo;
    logic [W-1:0] prod_hi;
    logic         overflow;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [2*W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vs;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[13];

    seq_mul16_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op_signed   (op_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .prod_lo     (prod_lo),
        .prod_hi     (prod_hi),
        .overflow    (overflow),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms);
        longint p;
        logic   ov;
        if (ms) p = longint'($signed(ma)) * longint'($signed(mb));
        else    p = longint'(ma) * longint'(mb);
        if (ms) ov = (p < -32768) || (p > 32767);
        else    ov = (p > 65535);
        return {ov, p[31:0]};
    endfunction

    // driver tasks: called and returning at 1 time unit after a rising edge
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        int n;
        n = 0;
        a = ta; b = tb_v; op_signed = ts; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'd17);
    endtask

    initial begin
        int lat;
        int got;
        int cyc;
        logic [2*W:0] e;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 1'b1};
        vecs[1]  = '{16'hFFFD, 16'h0005, 1'b1, 16'hFFFF, 16'hFFF1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000, 1'b1};
        vecs[3]  = '{16'h1234, 16'h0001, 1'b0, 16'h0000, 16'h1234, 1'b0};
        vecs[4]  = '{16'h0000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{16'h7FFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'h8001, 1'b0};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h4000, 16'h0000, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0001, 1'b0};
        vecs[8]  = '{16'h0100, 16'h0100, 1'b1, 16'h0001, 16'h0000, 1'b1};
        vecs[9]  = '{16'h00FF, 16'h00FF, 1'b0, 16'h0000, 16'hFE01, 1'b0};
        vecs[10] = '{16'h00FF, 16'h00FF, 1'b1, 16'h0000, 16'hFE01, 1'b1};
        vecs[11] = '{16'h8000, 16'h0001, 1'b1, 16'hFFFF, 16'h8000, 1'b0};
        vecs[12] = '{16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_prod", {prod_hi, prod_lo}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // table-driven directed vectors, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].va, vecs[i].vb, vecs[i].vs);
            check("busy_run", {31'd0, busy}, 32'd1);
            wait_done(lat);
            check("vec_hi", {16'd0, prod_hi}, {16'd0, vecs[i].e_hi});
            check("vec_lo", {16'd0, prod_lo}, {16'd0, vecs[i].e_lo});
            check("vec_ovf", {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
            @(posedge clk); #1;
            check("valid_one_cycle", {31'd0, out_valid}, 32'd0);
            check("idle_ready", {31'd0, in_ready}, 32'd1);
        end

        // backpressure in DONE with a competing operand pair
        out_ready = 1'b0;
        start_op(16'h0003, 16'h0004, 1'b0);
        wait_done(lat);
        a = 16'h00AA; b = 16'h0002; op_signed = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_prod", {prod_hi, prod_lo}, 32'h0000_000C);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_accepted", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("bp_new_prod", {prod_hi, prod_lo}, 32'h0000_0154);
        check("bp_new_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;

        // asynchronous reset during RUN iteration 8
        start_op(16'h1234, 16'h5678, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_prod", {prod_hi, prod_lo}, 32'h0000_0154);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_prod", {prod_hi, prod_lo}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        start_op(16'h00FF, 16'h0101, 1'b0);
        wait_done(lat);
        check("post_rst_prod", {prod_hi, prod_lo}, 32'h0000_FFFF);
        check("post_rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;

        // back-to-back randomized ops with random gaps and backpressure
        got = 0;
        fork
            begin : producer
                for (int i = 0; i < 20; i++) begin
                    int gap;
                    int n;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    a = 16'($urandom_range(0, 16'hFFFF));
                    b = 16'($urandom_range(0, 16'hFFFF));
                    op_signed = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    n = 0;
                    while (!in_ready && n < 200) begin
                        @(posedge clk); #1; n++;
                    end
                    if (!in_ready) begin
                        check("rand_accept_timeout", {31'd0, in_ready}, 32'd1);
                        in_valid = 1'b0;
                        break;
                    end
                    exp_q.push_back(model(a, b, op_signed));
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
            end
            begin : consumer
                cyc = 0;
                while (got < 20 && cyc < 3000) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rand_prod", {prod_hi, prod_lo}, e[31:0]);
                            check("rand_ovf", {31'd0, overflow}, {31'd0, e[32]});
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        check("rand_count", 32'(got), 32'd20);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
